regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Owns the single write port of the 32x8 register file (one write, two read ports).
//  Clears every register after reset, or on request, with an init sequencer.
//  Shares the write port between two requesters (0,1) using round-robin arbitration.
//  Drives WE/Writeaddress/In of the regfile from registered outputs; read ports are not touched.
// PARAMETERS
//  DATA_W    8   data width of each register
//  ADDR_W    5   address width; depth = 2**ADDR_W = 32
//  INIT_VAL  0   value written to every register during init (DATA_W bits)
// PORTS
//  CLK        in   1       clock, rising edge
//  RSTn       in   1       asynchronous active-low reset
//  init_req   in   1       level; request a full re-clear (sampled only in RUN)
//  req0       in   1       requester 0 write valid
//  addr0      in   ADDR_W  requester 0 write address
//  data0      in   DATA_W  requester 0 write data
//  rdy0       out  1       requester 0 ready (combinational)
//  req1       in   1       requester 1 write valid
//  addr1      in   ADDR_W  requester 1 write address
//  data1      in   DATA_W  requester 1 write data
//  rdy1       out  1       requester 1 ready (combinational)
//  WE         out  1       to regfile write enable (registered)
//  Writeaddr  out  ADDR_W  to regfile Writeaddress (registered)
//  WrData     out  DATA_W  to regfile In (registered)
//  init_done  out  1       1 while in RUN (registered)
// BEHAVIOUR
//  States: INIT, RUN. Registers: state, cnt[ADDR_W-1:0], prio (1 bit; requester with priority).
//  Reset (async, RSTn=0): state=INIT, cnt=0, prio=0, WE=0, Writeaddr=0, WrData=0, init_done=0.
//  INIT: rdy0=rdy1=0. On each edge: WE<=1, Writeaddr<=cnt, WrData<=INIT_VAL, cnt<=cnt+1.
//   When the edge writes cnt==DEPTH-1: state<=RUN, cnt<=0, init_done<=1.
//   So WE is high on exactly 32 consecutive cycles, addresses 0..31 in order,
//   starting on the first cycle after the first edge following RSTn release.
//   init_req and req0/req1 are ignored during INIT; init does not restart.
//  RUN with init_req=1: rdy0=rdy1=0, no transfer. Next edge: state<=INIT, cnt<=0,
//   init_done<=0, WE<=0. The INIT sequence then proceeds as above.
//  RUN with init_req=0: arbitration is combinational.
//   Only one requester valid: that requester is ready.
//   Both valid: the requester equal to prio is ready, the other is not. Neither valid: both 0.
//   Transfer = reqN & rdyN at an edge. On that edge:
//   WE<=1, Writeaddr<=addrN, WrData<=dataN, prio<=~N.
//   No transfer: WE<=0; Writeaddr and WrData hold their values; prio holds.
//  Latency: transfer edge k -> WE high cycle k+1 -> regfile captures at edge k+1.
//  Throughput: one write per cycle. Both requesters held continuously alternate 0,1,0,1,...
//   (starting from prio).
//  Requester rule: addrN/dataN must be stable while reqN=1 and rdyN=0. After a transfer,
//   reqN still high at the next edge is a new write.
//  Reset mid-INIT or mid-RUN: immediate return to reset values; the init restarts at address 0.
//   A transfer pending at the edge reset asserted is lost.
//  Outputs never carry X after reset.
// TESTING
//  1 Reset release -> WE=1 on 32 consecutive cycles, Writeaddr 0..31, WrData=0x00.
//    init_done rises with the cycle after addr 31; rdy0=rdy1=0 throughout.
//  2 RUN, req0 only, addr0=5, data0=0xA5 for 1 cycle -> rdy0=1 that cycle.
//    Next cycle WE=1, Writeaddr=5, WrData=0xA5; cycle after WE=0. Regfile reg5 reads 0xA5.
//  3 RUN, req0 and req1 held 6 cycles, prio=0 -> grants 0,1,0,1,0,1; WE high 6 cycles.
//    Writeaddr alternates addr0/addr1.
//  4 RUN, init_req=1 together with req1 -> rdy1=0, no write of addr1.
//    init_done falls, then 32 init writes of INIT_VAL, then req1 is served.
//  5 RSTn pulsed low during INIT at cnt=17 -> WE=0 and init_done=0 immediately.
//    After release the init restarts at address 0 for 32 writes.
//  6 Write 0x3C to addr 31 via req1 then read via RE_A, Readaddress_A=31 -> outA=0x3C.
//    Re-init then read -> outA=INIT_VAL.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for a 32x8 register file.
// After reset, or when init_req is seen in RUN, an init sequencer writes INIT_VAL
// to every address in order. Otherwise two requesters share the write port under
// round-robin arbitration. WE/Writeaddr/WrData leave this block registered.
module regfile_wr_arbiter #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              init_req,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              rdy0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              rdy1,
  output logic              WE,
  output logic [ADDR_W-1:0] Writeaddr,
  output logic [DATA_W-1:0] WrData,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic              prio, prio_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              init_done_d;
  logic              xfer0, xfer1;

  // Round-robin grant: a lone requester wins, a tie goes to the one named by prio.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (state == ST_RUN && !init_req) begin
      if (req0 && req1) begin
        rdy0 = ~prio;
        rdy1 = prio;
      end else begin
        rdy0 = req0;
        rdy1 = req1;
      end
    end
  end

  assign xfer0 = req0 & rdy0;
  assign xfer1 = req1 & rdy1;

  // Next-state: init sweep, re-init request, or the granted requester's write.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    prio_d      = prio;
    we_d        = 1'b0;
    waddr_d     = Writeaddr;
    wdata_d     = WrData;
    init_done_d = init_done;
    case (state)
      ST_INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt;
        wdata_d = INIT_VAL;
        cnt_d   = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (xfer0) begin
          we_d    = 1'b1;
          waddr_d = addr0;
          wdata_d = data0;
          prio_d  = 1'b1;
        end else if (xfer1) begin
          we_d    = 1'b1;
          waddr_d = addr1;
          wdata_d = data1;
          prio_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: every register here, outputs included, is reset so the regfile never
    // sees X on its write port; sequential state is updated with <= only.
    if (!RSTn) begin
      state     <= ST_INIT;
      cnt       <= '0;
      prio      <= 1'b0;
      WE        <= 1'b0;
      Writeaddr <= '0;
      WrData    <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      prio      <= prio_d;
      WE        <= we_d;
      Writeaddr <= waddr_d;
      WrData    <= wdata_d;
      init_done <= init_done_d;
    end
  end

endmodule
